// File: rtl/rgb_gray_reader_if.sv
`default_nettype none
// =============================================================================
// Module   : rgb_gray_reader_if
// Purpose  : RGB byte bus plus gray valid/ready and status bundle.
// Revision : 1.0
// =============================================================================
interface rgb_gray_reader_if;
   logic       start;
   logic [7:0] rgb_in;
   logic       rgb_valid;
   logic       pause;
   logic [7:0] gray_out;
   logic       gray_valid;
   logic       gray_ready;
   logic       busy;
   logic       done;
   logic       overflow;

   modport master (
      output start, rgb_in, rgb_valid, gray_ready,
      input  pause, gray_out, gray_valid, busy, done, overflow
   );

   modport slave (
      input  start, rgb_in, rgb_valid, gray_ready,
      output pause, gray_out, gray_valid, busy, done, overflow
   );
endinterface
`default_nettype wire

// File: rtl/rgb_gray_reader.sv
`default_nettype none
// =============================================================================
// Module   : rgb_gray_reader
// Purpose  : Reads R,G,B byte triplets through a 4-deep FIFO and emits 8-bit luma.
// Revision : 1.0
// =============================================================================
module rgb_gray_reader #(
   parameter int N  = 2,
   parameter int M  = 2,
   parameter int WR = 77,
   parameter int WG = 150,
   parameter int WB = 29
) (
   input wire               clk,
   input wire               rst,
   rgb_gray_reader_if.slave bus
);
   localparam int                C_PW   = (N * M > 1) ? $clog2(N * M) : 1;
   localparam logic [C_PW-1:0]   C_LAST = C_PW'(N * M - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_MULT  = 3'd2,
      S_OUT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_mem [4];
   logic [1:0]       r_wr_ptr, r_rd_ptr;
   logic [2:0]       r_count, w_count_nxt;
   logic [1:0]       r_byte_idx;
   logic [C_PW-1:0]  r_pix_cnt;
   logic [7:0]       r_r, r_g, r_b;
   logic [7:0]       r_gray_out;
   logic             r_gray_valid, r_pause, r_busy, r_done, r_overflow;
   logic             w_push_req, w_push, w_pop, w_full, w_flush, w_hs, w_last;
   logic [7:0]       w_luma;

   // A pop in the same cycle frees a slot, so a write to a full FIFO is only dropped without one
   assign w_full     = (r_count == 3'd4);
   assign w_pop      = (r_state == S_FETCH) && (r_count != 3'd0);
   assign w_push_req = bus.rgb_valid && r_busy;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_flush    = (r_state == S_DONE);
   assign w_hs       = (r_state == S_OUT) && bus.gray_ready;
   assign w_last     = (r_pix_cnt == C_LAST);
   assign w_luma     = 8'((16'(WR) * {8'd0, r_r} + 16'(WG) * {8'd0, r_g}
                          + 16'(WB) * {8'd0, r_b} + 16'd128) >> 8);

   always_comb begin
      w_count_nxt = r_count;
      if (w_flush)
         w_count_nxt = 3'd0;
      else if (w_push && !w_pop)
         w_count_nxt = r_count + 3'd1;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - 3'd1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
         S_FETCH: if (w_pop && r_byte_idx == 2'd2) w_state_nxt = S_MULT;
         S_MULT:  w_state_nxt = S_OUT;
         S_OUT:   if (bus.gray_ready) w_state_nxt = w_last ? S_DONE : S_FETCH;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= bus.rgb_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_pause    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_pause <= (w_count_nxt >= 3'd2);
         if (w_push_req && w_full && !w_pop)
            r_overflow <= 1'b1;
         if (w_flush) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_idx   <= 2'd0;
         r_pix_cnt    <= '0;
         r_r          <= 8'd0;
         r_g          <= 8'd0;
         r_b          <= 8'd0;
         r_gray_out   <= 8'd0;
         r_gray_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE && bus.start) begin
            r_busy     <= 1'b1;
            r_byte_idx <= 2'd0;
            r_pix_cnt  <= '0;
         end
         if (w_pop) begin
            case (r_byte_idx)
               2'd0:    r_r <= r_mem[r_rd_ptr];
               2'd1:    r_g <= r_mem[r_rd_ptr];
               default: r_b <= r_mem[r_rd_ptr];
            endcase
            r_byte_idx <= (r_byte_idx == 2'd2) ? 2'd0 : r_byte_idx + 2'd1;
         end
         if (r_state == S_MULT) begin
            r_gray_out   <= w_luma;
            r_gray_valid <= 1'b1;
         end
         // Entering DONE: done and the falling busy become visible together
         if (w_hs) begin
            r_gray_valid <= 1'b0;
            r_pix_cnt    <= r_pix_cnt + C_PW'(1);
            if (w_last) begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign bus.pause      = r_pause;
   assign bus.gray_out   = r_gray_out;
   assign bus.gray_valid = r_gray_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_rgb_gray_reader.sv
`default_nettype none
// =============================================================================
// Module   : tb_rgb_gray_reader
// Purpose  : Directed self-checking bench for rgb_gray_reader (N=M=2).
// Revision : 1.0
// =============================================================================
module tb_rgb_gray_reader;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rgb_gray_reader_if bus ();

   rgb_gray_reader #(.N(2), .M(2), .WR(77), .WG(150), .WB(29)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] fa [12];
   logic [7:0] ea [4];
   logic [7:0] fb [12];
   logic [7:0] eb [4];
   logic [7:0] t3 [8];
   int         first_gv, npix, ndone;
   bit         pause_seen;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Upstream obeys pause; pixels are compared at the cycle whose edge completes the handshake
   task automatic run_frame(input logic [7:0] px [12], input logic [7:0] ex [4],
                            input int hold, input int stop_pix, input int start_at,
                            output int fgv, output int pi, output int dones, output bit ps);
      int bi;
      int cyc;
      bi = 0; pi = 0; cyc = 0; dones = 0; fgv = -1; ps = 1'b0;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1);
      while (dones == 0 && cyc < 300 && pi < stop_pix) begin
         bus.gray_ready = (cyc >= hold);
         bus.start      = (cyc == start_at);
         if (bus.gray_valid && fgv < 0) fgv = cyc;
         if (bus.pause) ps = 1'b1;
         if (bus.gray_valid && bus.gray_ready) begin
            if (pi < 4) chk("gray_px", bus.gray_out, ex[pi]);
            pi++;
         end
         if (bus.done) begin
            dones++;
            chk("busy_falls_with_done", bus.busy, 0);
         end
         if (!bus.pause && bi < 12) begin
            bus.rgb_valid = 1'b1;
            bus.rgb_in    = px[bi];
            bi++;
         end else begin
            bus.rgb_valid = 1'b0;
         end
         tick;
         cyc++;
      end
      bus.rgb_valid = 1'b0;
      bus.start     = 1'b0;
   endtask

   initial begin
      fa = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd10, 8'd20, 8'd30};
      ea = '{8'd255, 8'd0, 8'd77, 8'd18};
      fb = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd100, 8'd100, 8'd100, 8'd1, 8'd2, 8'd3};
      eb = '{8'd149, 8'd29, 8'd100, 8'd2};
      t3 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};

      rst = 1'b1;
      bus.start = 1'b0; bus.rgb_in = 8'd0; bus.rgb_valid = 1'b0; bus.gray_ready = 1'b0;
      tick; tick;
      chk("rst_pause", bus.pause, 0);
      chk("rst_gray_out", bus.gray_out, 0);
      chk("rst_gray_valid", bus.gray_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_overflow", bus.overflow, 0);
      rst = 1'b0;
      tick;

      // Frame with downstream always ready
      run_frame(fa, ea, 0, 5, -1, first_gv, npix, ndone, pause_seen);
      chk("t1_latency", first_gv, 5);
      chk("t1_pixels", npix, 4);
      chk("t1_dones", ndone, 1);
      chk("t1_done_single", bus.done, 0);
      chk("t1_overflow", bus.overflow, 0);

      // Downstream stalled: pause must assert, nothing lost
      run_frame(fa, ea, 40, 5, -1, first_gv, npix, ndone, pause_seen);
      chk("t2_pause_seen", pause_seen, 1);
      chk("t2_pixels", npix, 4);
      chk("t2_dones", ndone, 1);
      chk("t2_overflow", bus.overflow, 0);

      // Ignore pause and overrun the FIFO
      bus.gray_ready = 1'b0;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("t3_ovf_before_drop", bus.overflow, 0);
         bus.rgb_valid = 1'b1;
         bus.rgb_in    = t3[i];
         tick;
      end
      bus.rgb_valid = 1'b0;
      chk("t3_ovf_after_drop", bus.overflow, 1);
      chk("t3_gray_valid", bus.gray_valid, 1);
      chk("t3_gray_first", bus.gray_out, 18);
      bus.gray_ready = 1'b1;
      repeat (20) tick;
      chk("t3_ovf_sticky", bus.overflow, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t3_ovf_cleared", bus.overflow, 0);
      tick;

      // Reset mid-frame after the second pixel handshake
      run_frame(fb, eb, 0, 2, -1, first_gv, npix, ndone, pause_seen);
      chk("t4_partial_pixels", npix, 2);
      bus.gray_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t4_rst_pause", bus.pause, 0);
      chk("t4_rst_gray_out", bus.gray_out, 0);
      chk("t4_rst_gray_valid", bus.gray_valid, 0);
      chk("t4_rst_busy", bus.busy, 0);
      chk("t4_rst_done", bus.done, 0);
      chk("t4_rst_overflow", bus.overflow, 0);
      tick;
      rst = 1'b0;
      tick;
      run_frame(fb, eb, 0, 5, -1, first_gv, npix, ndone, pause_seen);
      chk("t4_pixels", npix, 4);
      chk("t4_dones", ndone, 1);

      // Start pulsed mid-frame is ignored
      run_frame(fa, ea, 0, 5, 8, first_gv, npix, ndone, pause_seen);
      chk("t5_pixels", npix, 4);
      chk("t5_dones", ndone, 1);
      repeat (10) tick;
      chk("t5_busy_stays_low", bus.busy, 0);
      chk("t5_no_extra_done", bus.done, 0);

      // rgb_valid in IDLE must not load the FIFO
      bus.rgb_valid = 1'b1;
      bus.rgb_in    = 8'hAA;
      repeat (10) tick;
      chk("t6_pause", bus.pause, 0);
      chk("t6_gray_valid", bus.gray_valid, 0);
      chk("t6_busy", bus.busy, 0);
      bus.rgb_valid = 1'b0;
      run_frame(fa, ea, 0, 5, -1, first_gv, npix, ndone, pause_seen);
      chk("t6_pixels", npix, 4);
      chk("t6_dones", ndone, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
